// File: rtl/hex_display_pkg.sv
// Shared constants for the hex seven-segment scan driver.
// Segment patterns are gfedcba, active-high; drivers invert them.
package hex_display_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam logic [6:0] HEX_PAT [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   // Fewest hex digits able to show a value of the given bit width.
   function automatic int unsigned min_digits(input int unsigned width);
      return (width + 3) / 4;
   endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_seg
   import hex_display_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] seg
);

   assign seg = ~HEX_PAT[nib];

endmodule

// File: rtl/hex_scan_display.sv
// Time-multiplexed hex display driver: divider, digit scan, frame-aligned commit of
// loaded values, leading-zero blanking and registered active-low outputs.
module hex_scan_display
   import hex_display_pkg::*;
#(
   parameter int unsigned WIDTH       = 7,
   parameter int unsigned DIGITS      = 2,
   parameter int unsigned REFRESH_DIV = 100000,
   parameter int unsigned BLANK_LZ    = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [WIDTH-1:0]  value,
   input  logic              blank,
   output logic [DIGITS-1:0] an,
   output logic [6:0]        seg,
   output logic              frame
);

   localparam int unsigned CW = $clog2(REFRESH_DIV);
   localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int unsigned DW = DIGITS * 4;

   if (DIGITS < min_digits(WIDTH) || REFRESH_DIV < 2) begin : g_param_check
      $error("hex_scan_display: DIGITS too small for WIDTH or REFRESH_DIV < 2");
   end

   logic [CW-1:0]     cnt_q, cnt_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [WIDTH-1:0]  disp_q, disp_d;
   logic [WIDTH-1:0]  pend_q, pend_d;
   logic              pending_q, pending_d;
   logic              tc, wrap;

   logic [DW-1:0]     disp_ext, upper;
   logic [6:0]        nib_seg;
   logic              lz_blank;
   logic [DIGITS-1:0] an_d;
   logic [6:0]        seg_d;

   // Divider, scan index and frame-aligned commit of the pending value.
   always_comb begin
      tc        = (cnt_q == CW'(REFRESH_DIV - 1));
      wrap      = tc && (idx_q == IW'(DIGITS - 1));
      cnt_d     = tc ? '0 : cnt_q + CW'(1);
      idx_d     = idx_q;
      disp_d    = disp_q;
      pend_d    = pend_q;
      pending_d = pending_q;
      if (tc) begin
         idx_d = wrap ? '0 : idx_q + IW'(1);
      end
      if (wrap) begin
         pending_d = 1'b0;
         if (load) begin
            disp_d = value;
         end else if (pending_q) begin
            disp_d = pend_q;
         end
      end else if (load) begin
         pend_d    = value;
         pending_d = 1'b1;
      end
   end

   assign disp_ext = DW'(disp_q);
   // Nibbles at and above the current digit; all zero means a leading zero.
   assign upper    = disp_ext >> {idx_q, 2'b00};
   assign lz_blank = (BLANK_LZ != 0) && (idx_q != '0) && (upper == '0);

   hex_to_seg u_hex_to_seg (
      .nib (upper[3:0]),
      .seg (nib_seg)
   );

   always_comb begin
      an_d  = '1;
      seg_d = SEG_BLANK;
      if (!blank && !lz_blank) begin
         an_d[idx_q] = 1'b0;
         seg_d       = nib_seg;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= '0;
         idx_q     <= '0;
         disp_q    <= '0;
         pend_q    <= '0;
         pending_q <= 1'b0;
         an        <= '1;
         seg       <= SEG_BLANK;
         frame     <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         disp_q    <= disp_d;
         pend_q    <= pend_d;
         pending_q <= pending_d;
         an        <= an_d;
         seg       <= seg_d;
         frame     <= wrap;
      end
   end

endmodule

// File: tb/tb_hex_scan_display.sv
// Self-checking bench for hex_scan_display with REFRESH_DIV=4, DIGITS=2, WIDTH=7, BLANK_LZ=1.
// A time-based reference model predicts an/seg/frame from cycles elapsed since reset.
module tb_hex_scan_display;

   localparam int unsigned RD    = 4;
   localparam int unsigned DG    = 2;
   localparam int unsigned FRAME = RD * DG;

   localparam logic [6:0] PAT [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   logic       clk   = 1'b0;
   logic       rst   = 1'b1;
   logic       load  = 1'b0;
   logic       blank = 1'b0;
   logic [6:0] value = '0;
   logic [1:0] an;
   logic [6:0] seg;
   logic       frame;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   hex_scan_display #(
      .WIDTH       (7),
      .DIGITS      (DG),
      .REFRESH_DIV (RD),
      .BLANK_LZ    (1)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .load  (load),
      .value (value),
      .blank (blank),
      .an    (an),
      .seg   (seg),
      .frame (frame)
   );

   // Reference model: slot and frame position follow from the cycle count n.
   int unsigned n         = 0;
   logic [6:0]  m_disp    = '0;
   logic [6:0]  m_pend    = '0;
   logic        m_pending = 1'b0;
   logic [1:0]  exp_an    = 2'b11;
   logic [6:0]  exp_seg   = 7'h7F;
   logic        exp_frame = 1'b0;

   function automatic logic [8:0] model_out(input int unsigned slot, input int unsigned d,
                                            input logic b);
      int unsigned upper = d >> (4 * slot);
      logic [1:0]  a     = 2'b11;
      logic [6:0]  s     = 7'h7F;
      if (!b && !(slot > 0 && upper == 0)) begin
         a[slot] = 1'b0;
         s       = ~PAT[upper % 16];
      end
      return {a, s};
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         n         <= 0;
         m_disp    <= '0;
         m_pend    <= '0;
         m_pending <= 1'b0;
         exp_an    <= 2'b11;
         exp_seg   <= 7'h7F;
         exp_frame <= 1'b0;
      end else begin
         {exp_an, exp_seg} <= model_out((n / RD) % DG, m_disp, blank);
         exp_frame         <= (n % FRAME == FRAME - 1);
         if (n % FRAME == FRAME - 1) begin
            m_pending <= 1'b0;
            if (load) m_disp <= value;
            else if (m_pending) m_disp <= m_pend;
         end else if (load) begin
            m_pend    <= value;
            m_pending <= 1'b1;
         end
         n <= n + 1;
      end
   end

   task automatic wait_frame(input string name);
      bit seen = 0;
      for (int i = 0; i < 2 * FRAME && !seen; i++) begin
         @(negedge clk);
         seen = frame;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s: frame pulse not seen within %0d cycles, got frame=%b want 1",
                  name, 2 * FRAME, frame);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if ({an, seg, frame} !== {2'b11, 7'h7F, 1'b0}) begin
         errors++;
         $display("FAIL reset_hold: got an=%b seg=%h frame=%b want an=11 seg=7f frame=0",
                  an, seg, frame);
      end
      rst = 1'b0;
      repeat (5) @(negedge clk);
      load  = 1'b1;
      value = 7'h33;
      @(negedge clk);
      load = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if ({an, seg, frame} !== {2'b11, 7'h7F, 1'b0}) begin
         errors++;
         $display("FAIL reset_mid: got an=%b seg=%h frame=%b want an=11 seg=7f frame=0",
                  an, seg, frame);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({an, seg} !== {2'b10, 7'h40}) begin
         errors++;
         $display("FAIL reset_digit0: got an=%b seg=%h want an=10 seg=40", an, seg);
      end
      repeat (4) @(negedge clk);
      checks++;
      if ({an, seg} !== {2'b11, 7'h7F}) begin
         errors++;
         $display("FAIL reset_digit1_lz: got an=%b seg=%h want an=11 seg=7f", an, seg);
      end
      // The load before reset must have been discarded.
      for (int i = 0; i < 2 * FRAME; i++) begin
         @(negedge clk);
         checks++;
         if ({an, seg, frame} !== {exp_an, exp_seg, exp_frame} || seg === 7'h30) begin
            errors++;
            $display("FAIL reset_discard: got an=%b seg=%h frame=%b want an=%b seg=%h frame=%b",
                     an, seg, frame, exp_an, exp_seg, exp_frame);
         end
      end
   endtask

   task automatic test_load_mid_frame();
      while (n % FRAME != 2) @(negedge clk);
      load  = 1'b1;
      value = 7'h5A;
      @(negedge clk);
      load = 1'b0;
      for (int i = 0; i < 2 * FRAME && !frame; i++) begin
         checks++;
         if ({an, seg, frame} !== {exp_an, exp_seg, exp_frame} || seg === 7'h08) begin
            errors++;
            $display("FAIL load_hold: got an=%b seg=%h frame=%b want an=%b seg=%h frame=%b",
                     an, seg, frame, exp_an, exp_seg, exp_frame);
         end
         @(negedge clk);
      end
      checks++;
      if (frame !== 1'b1) begin
         errors++;
         $display("FAIL load_frame: got frame=%b want 1", frame);
      end
      @(negedge clk);
      checks++;
      if ({an, seg} !== {2'b10, 7'h08}) begin
         errors++;
         $display("FAIL load_digit0: got an=%b seg=%h want an=10 seg=08", an, seg);
      end
      repeat (4) @(negedge clk);
      checks++;
      if ({an, seg} !== {2'b01, 7'h12}) begin
         errors++;
         $display("FAIL load_digit1: got an=%b seg=%h want an=01 seg=12", an, seg);
      end
   endtask

   task automatic test_back_to_back();
      while (n % FRAME != 1) @(negedge clk);
      load  = 1'b1;
      value = 7'h12;
      @(negedge clk);
      load = 1'b0;
      @(negedge clk);
      load  = 1'b1;
      value = 7'h34;
      @(negedge clk);
      load = 1'b0;
      wait_frame("b2b_frame");
      @(negedge clk);
      checks++;
      if ({an, seg} !== {2'b10, 7'h19}) begin
         errors++;
         $display("FAIL b2b_digit0: got an=%b seg=%h want an=10 seg=19", an, seg);
      end
      repeat (4) @(negedge clk);
      checks++;
      if ({an, seg} !== {2'b01, 7'h30}) begin
         errors++;
         $display("FAIL b2b_digit1: got an=%b seg=%h want an=01 seg=30", an, seg);
      end
      // Neither '1' nor '2' of the overwritten load may ever be shown.
      for (int i = 0; i < FRAME; i++) begin
         @(negedge clk);
         checks++;
         if (seg === 7'h79 || seg === 7'h24 || seg !== exp_seg) begin
            errors++;
            $display("FAIL b2b_never12: got seg=%h want seg=%h", seg, exp_seg);
         end
      end
   endtask

   task automatic test_load_at_wrap();
      while (n % FRAME != FRAME - 1) @(negedge clk);
      load  = 1'b1;
      value = 7'h7F;
      @(negedge clk);
      load = 1'b0;
      checks++;
      if (frame !== 1'b1) begin
         errors++;
         $display("FAIL wrap_frame: got frame=%b want 1", frame);
      end
      @(negedge clk);
      checks++;
      if ({an, seg} !== {2'b10, 7'h0E}) begin
         errors++;
         $display("FAIL wrap_digit0: got an=%b seg=%h want an=10 seg=0e", an, seg);
      end
      repeat (4) @(negedge clk);
      checks++;
      if ({an, seg} !== {2'b01, 7'h78}) begin
         errors++;
         $display("FAIL wrap_digit1: got an=%b seg=%h want an=01 seg=78", an, seg);
      end
      wait_frame("wrap_second_frame");
      @(negedge clk);
      checks++;
      if ({an, seg} !== {2'b10, 7'h0E}) begin
         errors++;
         $display("FAIL wrap_unchanged: got an=%b seg=%h want an=10 seg=0e", an, seg);
      end
   endtask

   task automatic test_blank();
      int pulses = 0;
      blank = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         pulses += int'(frame);
         checks++;
         if (an !== 2'b11 || seg !== 7'h7F || frame !== exp_frame) begin
            errors++;
            $display("FAIL blank_off: got an=%b seg=%h frame=%b want an=11 seg=7f frame=%b",
                     an, seg, frame, exp_frame);
         end
      end
      blank = 1'b0;
      checks++;
      if (pulses < 1) begin
         errors++;
         $display("FAIL blank_frame_count: got %0d pulses want at least 1", pulses);
      end
      for (int i = 0; i < FRAME + 1; i++) begin
         @(negedge clk);
         checks++;
         if ({an, seg, frame} !== {exp_an, exp_seg, exp_frame}) begin
            errors++;
            $display("FAIL blank_resume: got an=%b seg=%h frame=%b want an=%b seg=%h frame=%b",
                     an, seg, frame, exp_an, exp_seg, exp_frame);
         end
      end
   endtask

   task automatic test_leading_zero();
      @(negedge clk);
      load  = 1'b1;
      value = 7'h05;
      @(negedge clk);
      load = 1'b0;
      wait_frame("lz_frame");
      @(negedge clk);
      checks++;
      if ({an, seg} !== {2'b10, 7'h12}) begin
         errors++;
         $display("FAIL lz_digit0: got an=%b seg=%h want an=10 seg=12", an, seg);
      end
      repeat (4) @(negedge clk);
      checks++;
      if ({an, seg} !== {2'b11, 7'h7F}) begin
         errors++;
         $display("FAIL lz_digit1: got an=%b seg=%h want an=11 seg=7f", an, seg);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         load  = ($urandom_range(0, 3) == 0);
         value = 7'($urandom);
         blank = ($urandom_range(0, 7) == 0);
         @(negedge clk);
         checks++;
         if ({an, seg, frame} !== {exp_an, exp_seg, exp_frame}) begin
            errors++;
            $display("FAIL random[%0d]: got an=%b seg=%h frame=%b want an=%b seg=%h frame=%b",
                     i, an, seg, frame, exp_an, exp_seg, exp_frame);
         end
      end
      load  = 1'b0;
      blank = 1'b0;
   endtask

   initial begin
      test_reset();
      test_load_mid_frame();
      test_back_to_back();
      test_load_at_wrap();
      test_blank();
      test_leading_zero();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hex_scan_display.md
# hex_scan_display

Time-multiplexed hexadecimal seven-segment driver that sits directly downstream of the sequence generator and consumes its WIDTH-bit output value. A load strobe captures a new value, which is committed to the display only at a frame boundary so a frame never shows a mix of old and new digits. Digits are scanned one at a time at a programmable refresh rate, with optional leading-zero blanking. The anode and segment outputs are active-low and registered.

## Interface
- WIDTH, 7: width of the displayed value.
- DIGITS, 2: number of hex digits scanned; must satisfy DIGITS*4 >= WIDTH.
- REFRESH_DIV, 100000: clk cycles per digit slot; must be >= 2.
- BLANK_LZ, 1: 1 blanks leading zero digits above digit 0.
- clk  in  1  clock; reset is asynchronous, active-high rst.
- rst  in  1  asynchronous, active-high reset.
- load  in  1  single-cycle strobe; captures value.
- value  in  WIDTH  value to display; zero-extended to DIGITS*4 bits.
- blank  in  1  level; forces all digits off while high.
- an  out  DIGITS  digit enables, active-low; an[i]=0 enables digit i (digit 0 = least significant nibble).
- seg  out  7  segments, active-low; seg[0]=a … seg[6]=g.
- frame  out  1  one-cycle pulse at each frame wrap.

## Operation
- Divider cnt counts 0..REFRESH_DIV-1. At the terminal count (tc), cnt returns to 0 and digit index idx advances, wrapping from DIGITS-1 to 0.
- Frame wrap: tc with idx==DIGITS-1.
- Load path: load sets pend<=value and pending<=1. A second load before the wrap overwrites pend; the last load wins.
- Commit at frame wrap:
  - If load is high in the same cycle, disp<=value (bypass).
  - Else if pending, disp<=pend.
  - pending is cleared in both cases.
- Digit i nibble is disp_ext[4i+3:4i], decoded with gfedcba active-high patterns: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71. seg is the inverse of the pattern.
- Leading-zero blanking: with BLANK_LZ=1, digit i>0 is blanked (an all ones, seg 7'h7F) when nibbles i..DIGITS-1 are all zero. Digit 0 is never blanked this way.
- blank high: an=all ones and seg=7'h7F. cnt, idx and the load/commit logic keep running.

## Timing
- Reset values:
  - cnt=0, idx=0, disp=0, pend=0, pending=0.
  - an=all ones, seg=7'h7F, frame=0.
- an, seg and frame are registered and reflect idx/disp/blank one cycle after the cycle that changes them.
- frame is high for exactly one cycle, the cycle after the frame wrap.
- Load-to-display latency is at most DIGITS*REFRESH_DIV+1 cycles. The value shows from the first digit slot of the next frame.
- rst asserted mid-frame: all state returns to reset values immediately; any pending load is discarded.
- After rst release, the first slot shows digit 0 at cycle 1.

## Structure
- Package hex_display_pkg:
  - SEG_BLANK=7'h7F.
  - 16-entry hex pattern constants.
  - Function for the DIGITS lower bound.
- One natural sub-module: hex_to_seg, a combinational 4-bit to 7-bit active-low decoder.
- Scan, divider and commit logic stay in hex_scan_display.

## Test plan
All scenarios use REFRESH_DIV=4, DIGITS=2, WIDTH=7, BLANK_LZ=1.
- Reset mid-scan → an=2'b11, seg=7'h7F, frame=0 during rst. After release: an=2'b10, seg=7'h40 (digit 0 shows '0'); digit-1 slot shows an=2'b11 (blanked).
- Load 7'h5A mid-frame → display unchanged until frame pulse. Next frame: slot 0 shows an=2'b10, seg=7'h08 ('A'); slot 1 shows an=2'b01, seg=7'h12 ('5').
- Load 7'h12 then 7'h34 in the same frame → next frame shows seg=7'h19 ('4') and seg=7'h30 ('3'); 12 never appears.
- Load 7'h7F coincident with frame wrap → next frame shows seg=7'h0E ('F') and seg=7'h78 ('7') immediately; a later wrap without a load leaves the display unchanged.
- blank high for 10 cycles → an=2'b11 throughout. frame still pulses every 8 cycles. After blank drops, the display resumes at the correct idx.
- Load 7'h05 → digit 1 blanked (an=2'b11 in its slot); digit 0 seg=7'h12.
